// File: rtl/branch_predict_resolve_if.sv
// Bus bundle between the fetch/execute stages and branch_predict_resolve.
// master drives the lookup PC and resolution requests; slave returns the prediction and results.
interface branch_predict_resolve_if;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [2:0]  res_funct3;
    logic        res_pred_taken;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic        taken_q;
    logic        done_q;
    logic        mispredict;
    logic        illegal_br;
    logic [15:0] mispred_cnt;

    modport master (
        output pred_pc, res_valid, res_pc, res_funct3, res_pred_taken, br_eq, br_lt, br_ltu,
        input  pred_taken, res_ready, taken_q, done_q, mispredict, illegal_br, mispred_cnt
    );

    modport slave (
        input  pred_pc, res_valid, res_pc, res_funct3, res_pred_taken, br_eq, br_lt, br_ltu,
        output pred_taken, res_ready, taken_q, done_q, mispredict, illegal_br, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch resolution, mispredict detection and a 2-bit saturating-counter BHT.
// Optional macro BHT_BYPASS_EN forwards a same-cycle update to the fetch lookup.
module branch_predict_resolve #(
    parameter int unsigned IDX_BITS = 4,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input logic                    CLK,
    input logic                    RST,
    branch_predict_resolve_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
    logic [1:0]          bht_q [DEPTH];

    logic [IDX_BITS-1:0] pred_idx, res_idx, wr_idx;
    logic [1:0]          res_ctr, upd_ctr, wr_ctr;
    logic                wr_en, accept, legal, taken, mis;
    logic                pred_taken;

    logic                taken_q, done_q, mispredict_q, illegal_q;
    logic [15:0]         mispred_cnt_q, mispred_cnt_d;

    logic                unused_pc_bits;

    assign pred_idx = bus.pred_pc[IDX_BITS+1:2];
    assign res_idx  = bus.res_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_BITS+2], bus.pred_pc[1:0],
                              bus.res_pc[31:IDX_BITS+2], bus.res_pc[1:0]};

    assign bus.res_ready = (state_q == ST_RUN);
    assign accept        = bus.res_valid && bus.res_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (bus.res_funct3)
            3'b000:  taken = bus.br_eq;
            3'b001:  taken = !bus.br_eq;
            3'b100:  taken = bus.br_lt;
            3'b101:  taken = !bus.br_lt;
            3'b110:  taken = bus.br_ltu;
            3'b111:  taken = !bus.br_ltu;
            default: legal = 1'b0;
        endcase
    end

    assign res_ctr = bht_q[res_idx];
    assign upd_ctr = taken ? ((res_ctr == 2'b11) ? res_ctr : res_ctr + 2'd1)
                           : ((res_ctr == 2'b00) ? res_ctr : res_ctr - 2'd1);
    assign mis     = legal && (taken != bus.res_pred_taken);

    always_comb begin
        pred_taken = 1'b0;
        if (state_q == ST_RUN) begin
            pred_taken = bht_q[pred_idx][1];
`ifdef BHT_BYPASS_EN
            if (accept && legal && (pred_idx == res_idx))
                pred_taken = upd_ctr[1];
`endif
        end
    end

    // Single table write port shared by the init sweep and resolution training.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        wr_en      = 1'b0;
        wr_idx     = init_idx_q;
        wr_ctr     = INIT_CTR;
        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                init_idx_d = init_idx_q + 1'b1;
                if (&init_idx_q)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept && legal) begin
                    wr_en  = 1'b1;
                    wr_idx = res_idx;
                    wr_ctr = upd_ctr;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign mispred_cnt_d = (accept && mis && (mispred_cnt_q != 16'hFFFF))
                           ? mispred_cnt_q + 16'd1 : mispred_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_INIT;
            init_idx_q    <= '0;
            taken_q       <= 1'b0;
            done_q        <= 1'b0;
            mispredict_q  <= 1'b0;
            illegal_q     <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            if (accept)
                taken_q <= taken;
            done_q        <= accept;
            mispredict_q  <= accept && mis;
            illegal_q     <= accept && !legal;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // NOTE: the table has no reset term; the INIT sweep fills it, which keeps it mappable to RAM.
    always_ff @(posedge CLK) begin
        if (wr_en && !RST)
            bht_q[wr_idx] <= wr_ctr;
    end

    assign bus.pred_taken  = pred_taken;
    assign bus.taken_q     = taken_q;
    assign bus.done_q      = done_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.illegal_br  = illegal_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Consumer side of the branch-condition flags (br_eq, br_lt, br_ltu) in the OTTER pipeline.
- Decodes the B-type funct3 against the flags to resolve each branch as taken or not taken.
- Compares the resolution with the prediction issued at fetch and flags a mispredict for pipeline flush.
- Owns a direct-mapped table of 2-bit saturating counters that supplies fetch-stage predictions and is trained on every resolution.

Parameters:
- IDX_BITS, 4, table index width; table depth = 2**IDX_BITS entries.
- INIT_CTR, 2'b01, counter value written into every entry during table initialisation (weakly not-taken).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- pred_pc  in  32  fetch PC; index = pred_pc[IDX_BITS+1:2].
- pred_taken  out  1  combinational prediction: MSB of the indexed counter; 0 while in INIT.
- res_valid  in  1  resolution request; accepted when res_valid && res_ready.
- res_ready  out  1  high only in RUN state.
- res_pc  in  32  PC of the resolving branch; index = res_pc[IDX_BITS+1:2].
- res_funct3  in  3  branch funct3.
- res_pred_taken  in  1  prediction that fetch used for this branch.
- br_eq, br_lt, br_ltu  in  1 each  flags from the branch condition generator.
- taken_q  out  1  registered resolved direction.
- done_q  out  1  one-cycle pulse, cycle after acceptance.
- mispredict  out  1  one-cycle pulse: taken != res_pred_taken for a legal branch.
- illegal_br  out  1  one-cycle pulse: funct3 is 010 or 011.
- mispred_cnt  out  16  saturating mispredict counter.

Behaviour:
- FSM states: INIT, RUN.
  - RST forces INIT with init index 0.
  - INIT writes INIT_CTR to one entry per cycle, index 0 upward.
  - After writing the last entry (2**IDX_BITS cycles), the FSM moves to RUN.
  - RUN persists until RST.
- RST asserted in any state, including mid-INIT: restart at index 0. taken_q, done_q, mispredict, illegal_br and mispred_cnt clear to 0 on the same edge; res_ready = 0 next cycle.
- Outputs during INIT: res_ready = 0, pred_taken = 0. res_valid is ignored (no outputs, no table write).
- Funct3 decode:
  - 000 taken = br_eq
  - 001 taken = !br_eq
  - 100 taken = br_lt
  - 101 taken = !br_lt
  - 110 taken = br_ltu
  - 111 taken = !br_ltu
  - 010, 011 taken = 0, illegal_br = 1, no table write, no mispredict.
- Latency: request accepted in cycle N → done_q, taken_q, mispredict, illegal_br valid in cycle N+1. Pulses deassert in N+2 unless another request is accepted in N+1. Back-to-back acceptance every cycle is supported.
- Table update on an accepted legal branch, at the edge ending cycle N:
  - taken: counter = min(ctr+1, 3).
  - not taken: counter = max(ctr-1, 0).
- mispred_cnt increments at the same edge mispredict is registered and saturates at 16'hFFFF.
- Same index looked up and updated in one cycle: pred_taken returns the pre-update value (read-before-write), unless the feature below is enabled.
- taken_q holds its last value when no request is accepted.

Optional Feature:
- Macro: BHT_BYPASS_EN.
- When defined: if res_valid && res_ready, the branch is legal, and pred_pc index == res_pc index, pred_taken is the MSB of the post-update counter value, forwarded combinationally.
- When undefined: pred_taken is the read-before-write value.
- Nothing else changes.

Test Plan:
- Pulse RST 1 cycle with IDX_BITS=4 → res_ready low for exactly 16 cycles, then high. pred_taken = 0 for pred_pc = 0x00 … 0x3C.
- In RUN, res_pc=0x100, funct3=000, br_eq=1, res_pred_taken=0 → next cycle taken_q=1, done_q=1, mispredict=1, mispred_cnt=1. Afterwards pred_pc=0x100 gives pred_taken=1 (counter 10).
- Three further taken BEQ at 0x100 → counter saturates at 11. One not-taken BNE (funct3=001, br_eq=1) → counter 10, pred_taken stays 1, mispredict=1 if res_pred_taken=1.
- funct3=010 with res_valid → illegal_br=1, done_q=1, taken_q=0, mispredict=0, counter at that index unchanged, mispred_cnt unchanged.
- pred_pc=res_pc=0x104 in the same cycle, counter 01, taken branch → pred_taken=0 without BHT_BYPASS_EN; pred_taken=1 with it.
- Assert RST at INIT cycle 5 → index restarts at 0. res_ready rises exactly 16 cycles after RST deasserts. res_valid during INIT produces no done_q pulse.
